// File: rtl/xor_or_pkg.sv
// Shared defaults for the registered (a ^ b) | c pipeline.
// WIDTH is the operand/result width, CNT_W the delivered-result counter width.
package xor_or_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

endpackage : xor_or_pkg

// File: rtl/xor_or_pipeline_pipe_reg_slice.sv
// One valid/ready register stage: holds a single item and accepts a new one
// whenever it is empty or its current item leaves in the same cycle.
module pipe_reg_slice #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule : pipe_reg_slice

// File: rtl/xor_or_pipeline.sv
// Two-slice flow-controlled pipeline computing x = (a ^ b) | c, with a
// saturating count of results handed to the downstream consumer.
module xor_or_pipeline
  import xor_or_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [CNT_W-1:0] out_count
);

  logic               s1_valid;
  logic               s2_ready;
  logic [2*WIDTH-1:0] s1_in;
  logic [2*WIDTH-1:0] s1_data;
  logic [WIDTH-1:0]   s1_ab, s1_c, s2_in;
  logic [CNT_W-1:0]   count_q, count_d;

  assign s1_in = {a ^ b, c};

  pipe_reg_slice #(.DW(2*WIDTH)) u_slice1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  // The OR sits between the slices so slice 2 only stores the final result.
  assign s1_ab = s1_data[2*WIDTH-1:WIDTH];
  assign s1_c  = s1_data[WIDTH-1:0];
  assign s2_in = s1_ab | s1_c;

  pipe_reg_slice #(.DW(WIDTH)) u_slice2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (x)
  );

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;

endmodule : xor_or_pipeline
